// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared state type, default timings and lamp helper for ped_crossing_ctrl
package ped_pkg;

  // Default crossing timings, in clock cycles
  localparam int PED_WALK_CYCLES  = 20;
  localparam int PED_FLASH_CYCLES = 10;
  localparam int PED_FLASH_HALF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RED,
    ST_WALK,
    ST_FLASH,
    ST_CLEAR,
    ST_FAULT
  } ped_state_e;

  // Exactly one vehicle lamp lit is the only legal combination
  function automatic logic lamps_one_hot(input logic red, input logic yellow, input logic green);
    return (red & ~yellow & ~green) | (~red & yellow & ~green) | (~red & ~yellow & green);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer with rising-edge detect for the push-button
//
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset, clears all flops
//   i_btn   - raw asynchronous push-button level
//   o_edge  - one-cycle pulse on a synchronized rising edge of i_btn
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_sync2_d;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian crossing controller slaved to a vehicle traffic light
//
// Optional feature: define PED_CHIRP_EN to build the audible chirp driver;
// otherwise chirp is tied low.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   red        - vehicle red lamp (synchronous)
//   yellow     - vehicle yellow lamp (synchronous)
//   green      - vehicle green lamp (synchronous)
//   ped_btn    - raw pedestrian push-button (asynchronous level)
//   ped_req    - registered crossing request to the traffic light
//   walk       - walk lamp
//   dont_walk  - don't-walk lamp (flashes near the end of the crossing)
//   countdown  - remaining crossing cycles, 0 outside WALK/FLASH
//   fault      - sticky illegal-lamp flag, cleared only by reset
//   chirp      - audible signal drive
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = PED_WALK_CYCLES,
  parameter int FLASH_CYCLES = PED_FLASH_CYCLES,
  parameter int FLASH_HALF   = PED_FLASH_HALF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       ped_btn,
  output logic       ped_req,
  output logic       walk,
  output logic       dont_walk,
  output logic [7:0] countdown,
  output logic       fault,
  output logic       chirp
);

  localparam int               HALF_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [7:0]       CD_LOAD   = 8'(WALK_CYCLES + FLASH_CYCLES - 1);
  localparam logic [7:0]       CD_FLASH  = 8'(FLASH_CYCLES);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(FLASH_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);

  // The 8-bit countdown must hold the full crossing, and the phase timers
  // need at least one cycle each.
  if ((WALK_CYCLES + FLASH_CYCLES) > 256 || FLASH_HALF == 0 ||
      WALK_CYCLES < 1 || FLASH_CYCLES < 1) begin : g_param_check
    $error("ped_crossing_ctrl: illegal WALK_CYCLES/FLASH_CYCLES/FLASH_HALF combination");
  end

  logic              w_btn_edge;
  logic              w_red_rise;
  logic              w_lamps_ok;

  ped_state_e        r_state;
  logic              r_pending;
  logic              r_walk;
  logic              r_dont_walk;
  logic [7:0]        r_countdown;
  logic              r_fault;
  logic [HALF_W-1:0] r_half_cnt;
  logic              r_red_d;
`ifdef PED_CHIRP_EN
  logic              r_chirp;
`endif

  btn_sync_edge u_btn_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (ped_btn),
    .o_edge (w_btn_edge)
  );

  // Red history for rising-edge detection; a red already lit when the
  // request arrives must not start a crossing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_red_d <= 1'b0;
    end else begin
      r_red_d <= red;
    end
  end

  assign w_red_rise = red & ~r_red_d;
  assign w_lamps_ok = lamps_one_hot(red, yellow, green);

  // The request line and the pending flag are the same piece of state:
  // both set on a button edge and both clear on WALK entry or FAULT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b0;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_countdown <= 8'd0;
      r_fault     <= 1'b0;
      r_half_cnt  <= '0;
`ifdef PED_CHIRP_EN
      r_chirp     <= 1'b0;
`endif
    end else if (!w_lamps_ok || r_state == ST_FAULT) begin
      // Illegal lamps win over everything, including a coincident button edge
      r_state     <= ST_FAULT;
      r_fault     <= 1'b1;
      r_pending   <= 1'b0;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_countdown <= 8'd0;
`ifdef PED_CHIRP_EN
      r_chirp     <= 1'b0;
`endif
    end else if ((r_state == ST_WALK || r_state == ST_FLASH) && !red) begin
      // Vehicles released early: abandon the crossing
      if (w_btn_edge) r_pending <= 1'b1;
      r_state     <= ST_CLEAR;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_countdown <= 8'd0;
`ifdef PED_CHIRP_EN
      r_chirp     <= 1'b0;
`endif
    end else begin
      if (w_btn_edge) r_pending <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_btn_edge) r_state <= ST_WAIT_RED;
        end
        ST_WAIT_RED: begin
          if (w_red_rise) begin
            // Clearing here also absorbs a press landing on the same edge
            r_state     <= ST_WALK;
            r_pending   <= 1'b0;
            r_walk      <= 1'b1;
            r_dont_walk <= 1'b0;
            r_countdown <= CD_LOAD;
`ifdef PED_CHIRP_EN
            r_chirp     <= 1'b1;
`endif
          end
        end
        ST_WALK: begin
          r_countdown <= r_countdown - 8'd1;
          if (r_countdown == CD_FLASH) begin
            r_state     <= ST_FLASH;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_half_cnt  <= HALF_LOAD;
`ifdef PED_CHIRP_EN
            r_chirp     <= 1'b1;
`endif
          end else begin
`ifdef PED_CHIRP_EN
            r_chirp     <= ~r_chirp;
`endif
          end
        end
        ST_FLASH: begin
          if (r_countdown == 8'd0) begin
            r_state     <= ST_CLEAR;
            r_dont_walk <= 1'b1;
`ifdef PED_CHIRP_EN
            r_chirp     <= 1'b0;
`endif
          end else begin
            r_countdown <= r_countdown - 8'd1;
            if (r_half_cnt == '0) begin
              r_half_cnt  <= HALF_LOAD;
              r_dont_walk <= ~r_dont_walk;
`ifdef PED_CHIRP_EN
              r_chirp     <= ~r_dont_walk;
`endif
            end else begin
              r_half_cnt  <= r_half_cnt - HALF_ONE;
            end
          end
        end
        ST_CLEAR: begin
          r_state <= (r_pending || w_btn_edge) ? ST_WAIT_RED : ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ped_req   = r_pending;
  assign walk      = r_walk;
  assign dont_walk = r_dont_walk;
  assign countdown = r_countdown;
  assign fault     = r_fault;

`ifdef PED_CHIRP_EN
  assign chirp = r_chirp;
`else
  assign chirp = 1'b0;
`endif

endmodule
